// File: rtl/ks_sum.sv
// Output stage of the pipelined Kogge-Stone adder: forms sum and flags from the
// final prefix bundle and delivers them through a 2-entry skid buffer.
module ks_sum #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic             i_c0,
   input  logic [WIDTH-1:0] i_pk,
   input  logic [WIDTH-1:0] i_gk,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
   output logic             o_ovf,
   output logic             o_zero,
   output logic [CNT_W-1:0] o_count
);

   if (WIDTH != 32) begin : g_width_chk
      $error("ks_sum: only WIDTH=32 is supported");
   end

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
      logic             zero;
   } res_t;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t     st;
   res_t       out_r, skid_r, nxt;
   logic [WIDTH-1:0] sum_c;
   logic       accept, xfer;

   // carry into bit k is the group generate of bits [k-1:0]; c0 feeds bit 0
   assign sum_c    = i_pk ^ {i_gk[WIDTH-2:0], i_c0};
   assign nxt.sum  = sum_c;
   assign nxt.cout = i_gk[WIDTH-1];
   assign nxt.ovf  = i_gk[WIDTH-1] ^ i_gk[WIDTH-2];
   assign nxt.zero = (sum_c == '0);

   assign accept = i_valid & o_ready;
   assign xfer   = o_valid & i_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         st      <= EMPTY;
         o_valid <= 1'b0;
         o_ready <= 1'b1;
         out_r   <= '0;
         skid_r  <= '0;
         o_count <= '0;
      end else begin
         if (xfer) o_count <= o_count + CNT_W'(1);
         case (st)
            EMPTY: begin
               if (accept) begin
                  out_r   <= nxt;
                  o_valid <= 1'b1;
                  st      <= ONE;
               end
            end
            ONE: begin
               if (accept && xfer) begin
                  out_r <= nxt;
               end else if (accept) begin
                  skid_r  <= nxt;
                  o_ready <= 1'b0;
                  st      <= FULL;
               end else if (xfer) begin
                  o_valid <= 1'b0;
                  st      <= EMPTY;
               end
            end
            FULL: begin
               // o_ready is low here, so only the drain path exists
               if (xfer) begin
                  out_r   <= skid_r;
                  o_ready <= 1'b1;
                  st      <= ONE;
               end
            end
            default: begin
               st      <= EMPTY;
               o_valid <= 1'b0;
               o_ready <= 1'b1;
            end
         endcase
      end
   end

   assign o_sum  = out_r.sum;
   assign o_cout = out_r.cout;
   assign o_ovf  = out_r.ovf;
   assign o_zero = out_r.zero;

endmodule

// File: tb/tb_ks_sum.sv
// Directed and random checks of ks_sum against a golden a+b+c0 model with an
// in-order scoreboard fed from accepted bundles.
module tb_ks_sum;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b1;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic        i_c0 = 1'b0;
   logic [31:0] i_pk = '0;
   logic [31:0] i_gk = '0;
   logic        o_valid;
   logic        i_ready = 1'b0;
   logic [31:0] o_sum;
   logic        o_cout, o_ovf, o_zero;
   logic [15:0] o_count;

   int nchk = 0;
   int nerr = 0;

   logic [31:0] cur_a = '0, cur_b = '0;
   logic        cur_c0 = 1'b0;
   logic [34:0] sb_q[$];
   logic        hold_prev = 1'b0;
   logic [34:0] prev_res = '0;

   ks_sum #(.WIDTH(32), .CNT_W(16)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_c0(i_c0), .i_pk(i_pk), .i_gk(i_gk), .o_valid(o_valid), .i_ready(i_ready),
      .o_sum(o_sum), .o_cout(o_cout), .o_ovf(o_ovf), .o_zero(o_zero), .o_count(o_count)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [34:0] golden(input logic [31:0] a, b, input logic c0);
      logic [32:0] s;
      logic        ovf;
      s   = {1'b0, a} + {1'b0, b} + {32'd0, c0};
      ovf = (a[31] == b[31]) && (s[31] != a[31]);
      return {s[31:0], s[32], ovf, s[31:0] == 32'd0};
   endfunction

   // ripple-carry reference for the prefix stage that feeds this block
   task automatic set_bundle(input logic [31:0] a, b, input logic c0);
      logic c;
      cur_a = a; cur_b = b; cur_c0 = c0;
      i_pk = a ^ b;
      i_c0 = c0;
      c = c0;
      for (int k = 0; k < 32; k++) begin
         c = (a[k] & b[k]) | ((a[k] ^ b[k]) & c);
         i_gk[k] = c;
      end
   endtask

   task automatic cyc();
      @(posedge i_clk); #1;
   endtask

   task automatic do_reset();
      i_valid = 1'b0;
      i_rst_n = 1'b0;
      repeat (2) cyc();
      i_rst_n = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && (o_valid || sb_q.size() != 0); i++) cyc();
      chk("drain_done", 64'(!o_valid && sb_q.size() == 0), 64'd1);
   endtask

   // negedge monitor: inputs and outputs are both settled here
   always @(negedge i_clk) begin
      if (!i_rst_n) begin
         sb_q.delete();
         hold_prev <= 1'b0;
      end else begin
         if (hold_prev)
            chk("stable", {o_valid, o_sum, o_cout, o_ovf, o_zero}, {1'b1, prev_res});
         if (o_valid && i_ready) begin
            chk("sb_occ", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0)
               chk("res", {o_sum, o_cout, o_ovf, o_zero}, sb_q.pop_front());
         end
         if (i_valid && o_ready) sb_q.push_back(golden(cur_a, cur_b, cur_c0));
         hold_prev <= o_valid && !i_ready;
         prev_res  <= {o_sum, o_cout, o_ovf, o_zero};
      end
   end

   initial begin
      int sent, cyc_n;
      logic acc;
      #2 i_rst_n = 1'b0;
      #1;
      chk("rst_valid", o_valid, 0);
      chk("rst_ready", o_ready, 1);
      chk("rst_sum", o_sum, 0);
      chk("rst_flags", {o_cout, o_ovf, o_zero}, 0);
      chk("rst_count", o_count, 0);
      repeat (2) cyc();
      i_rst_n = 1'b1;

      // directed arithmetic vectors
      i_ready = 1'b1;
      set_bundle(32'h7FFFFFFF, 32'h1, 1'b0); i_valid = 1'b1;
      cyc(); i_valid = 1'b0;
      chk("v1_valid", o_valid, 1);
      chk("v1_sum", o_sum, 32'h80000000);
      chk("v1_flags", {o_cout, o_ovf, o_zero}, 3'b010);
      cyc();
      chk("v1_count", o_count, 1);
      chk("v1_empty", o_valid, 0);

      set_bundle(32'hFFFFFFFF, 32'h1, 1'b0); i_valid = 1'b1;
      cyc(); i_valid = 1'b0;
      chk("v2_sum", o_sum, 32'h0);
      chk("v2_flags", {o_cout, o_ovf, o_zero}, 3'b101);
      cyc();

      set_bundle(32'h0, 32'h0, 1'b1); i_valid = 1'b1;
      cyc(); i_valid = 1'b0;
      chk("v3_sum", o_sum, 32'h1);
      chk("v3_flags", {o_cout, o_ovf, o_zero}, 3'b000);
      cyc();
      chk("v3_count", o_count, 3);

      // back-pressure: fill OUT and SKID, third bundle must wait
      do_reset();
      i_ready = 1'b0;
      set_bundle(32'd1, 32'd2, 1'b0); i_valid = 1'b1;
      cyc();
      chk("bp_ready1", o_ready, 1);
      set_bundle(32'd10, 32'd20, 1'b0);
      cyc();
      chk("bp_ready2", o_ready, 0);
      chk("bp_out1", {o_valid, o_sum}, {1'b1, 32'd3});
      set_bundle(32'h100, 32'h200, 1'b1);
      cyc();
      chk("bp_hold_rdy", o_ready, 0);
      chk("bp_hold_sum", o_sum, 32'd3);
      i_ready = 1'b1;
      cyc();
      chk("bp_out2", o_sum, 32'h1E);
      chk("bp_ready3", o_ready, 1);
      cyc(); i_valid = 1'b0;
      chk("bp_out3", o_sum, 32'h301);
      cyc();
      chk("bp_count", o_count, 3);
      chk("bp_empty", o_valid, 0);

      // random traffic with random handshakes; garbage on the bus while idle
      sent = 0; cyc_n = 0;
      set_bundle($urandom, $urandom, 1'($urandom));
      while (sent < 1000 && cyc_n < 20000) begin
         i_valid = 1'($urandom);
         i_ready = ($urandom_range(0, 3) != 0);
         if (i_valid) begin
            set_bundle(cur_a, cur_b, cur_c0);
         end else begin
            i_pk = $urandom; i_gk = $urandom; i_c0 = 1'($urandom);
         end
         acc = i_valid && o_ready;
         cyc(); cyc_n++;
         if (acc) begin
            sent++;
            set_bundle($urandom, $urandom, 1'($urandom));
         end
      end
      chk("rnd_sent", sent, 1000);
      i_valid = 1'b0; i_ready = 1'b1;
      drain();

      // reset while FULL discards everything in flight
      i_ready = 1'b0;
      set_bundle(32'hDEAD0000, 32'h0000BEEF, 1'b0); i_valid = 1'b1;
      cyc();
      set_bundle(32'h12345678, 32'h11111111, 1'b0);
      cyc(); i_valid = 1'b0;
      chk("mid_full", o_ready, 0);
      #2 i_rst_n = 1'b0;
      #1;
      chk("mid_valid", o_valid, 0);
      chk("mid_ready", o_ready, 1);
      chk("mid_count", o_count, 0);
      repeat (2) cyc();
      i_rst_n = 1'b1;
      i_ready = 1'b1;
      set_bundle(32'd40, 32'd2, 1'b0); i_valid = 1'b1;
      cyc(); i_valid = 1'b0;
      chk("post_sum", o_sum, 32'd42);
      drain();
      chk("post_count", o_count, 1);

      // counter wrap
      do_reset();
      i_ready = 1'b1;
      i_valid = 1'b1;
      for (int i = 0; i < 65535; i++) begin
         set_bundle(i, 32'd7, 1'b0);
         cyc();
      end
      i_valid = 1'b0;
      drain();
      chk("cnt_max", o_count, 16'hFFFF);
      set_bundle(32'd5, 32'd5, 1'b0); i_valid = 1'b1;
      cyc(); i_valid = 1'b0;
      drain();
      chk("cnt_wrap", o_count, 16'h0000);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/ks_sum.md
Name: ks_sum

Overview:
- Output stage of the pipelined 32-bit Kogge-Stone adder.
- Consumes the final prefix-stage bundle: carry-in, saved bitwise propagate, and fully resolved group-generate/carry vector.
- Produces the registered sum and the flags carry-out, signed overflow and zero.
- Adds a valid/ready handshake with a 2-entry skid buffer so downstream back-pressure never drops a result. Also keeps a count of completed results.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported; any other value is an elaboration error.
- CNT_W, 16, width of the completed-result counter.

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  input bundle valid
- o_ready  output  1  block can accept a bundle this cycle
- i_c0  input  1  adder carry-in
- i_pk  input  32  saved bitwise propagate, a^b
- i_gk  input  32  resolved carries; i_gk[k] = carry out of bit k, including c0
- o_valid  output  1  result valid
- i_ready  input  1  downstream accepts result
- o_sum  output  32  sum
- o_cout  output  1  carry out
- o_ovf  output  1  signed overflow
- o_zero  output  1  sum == 0
- o_count  output  CNT_W  results delivered downstream

Behaviour:
- Arithmetic, combinational on the accepted bundle:
  - s[0] = p[0] ^ c0
  - s[k] = p[k] ^ gk[k-1] for k = 1..31
  - cout = gk[31]
  - ovf = gk[31] ^ gk[30]
  - zero = (s == 0)
- The result is computed at acceptance and stored as a 35-bit entry {sum, cout, ovf, zero}. It is never recomputed later.
- Storage: output register OUT (drives o_*) plus one skid register SKID, each with a valid bit.
- Input accept: i_valid & o_ready. Output transfer: o_valid & i_ready.
- o_ready is a registered signal, equal to ~SKID.valid. It does not depend combinationally on i_ready.
- States:
  - EMPTY: OUT invalid, SKID invalid.
  - ONE: OUT valid, SKID invalid.
  - FULL: OUT valid, SKID valid.
- EMPTY transitions:
  - Accept: entry goes to OUT; next state ONE.
- ONE transitions:
  - Accept with transfer: entry replaces OUT; stay ONE.
  - Accept without transfer: entry goes to SKID; next state FULL, o_ready drops next cycle.
  - Transfer without accept: next state EMPTY.
- FULL transitions:
  - No accept is possible, because o_ready = 0.
  - Transfer: SKID moves to OUT; next state ONE, o_ready rises next cycle.
- Latency: one cycle from acceptance to o_valid when OUT is empty or draining. Results leave strictly in acceptance order.
- Throughput: one result per cycle when i_ready is held high.
- o_sum and the flags hold stable while o_valid & ~i_ready. This is required AXI-style stability.
- Output values while o_valid = 0 are don't-care, but the RTL holds the last value.
- o_count increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0. It is never cleared except by reset.
- Reset, asynchronous assertion:
  - Immediately o_valid = 0, o_ready = 1, o_sum = 0, o_cout = 0, o_ovf = 0, o_zero = 0, o_count = 0.
  - Both valid bits clear; any in-flight entries are discarded.
- Reset deassertion takes effect synchronously on the next i_clk edge. The first accept is possible in the first cycle after deassertion.
- i_pk, i_gk and i_c0 are sampled only when accepted. X on them while i_valid = 0 must not propagate.

Test Plan:
- Reset, then A=0x7FFFFFFF, B=1, c0=0 (i_pk=0x7FFFFFFE, i_gk=0x7FFFFFFF) with i_ready=1 -> next cycle o_valid=1, o_sum=0x80000000, o_cout=0, o_ovf=1, o_zero=0, o_count=1 after the transfer.
- A=0xFFFFFFFF, B=1 (i_pk=0xFFFFFFFE, i_gk=0xFFFFFFFF, c0=0) -> o_sum=0, o_cout=1, o_ovf=0, o_zero=1.
- A=B=0 with c0=1 (i_pk=0, i_gk=0) -> o_sum=0x00000001, all flags 0.
- Hold i_ready=0 and offer 3 back-to-back bundles:
  - The first two are accepted; o_ready=0 from the cycle after the second accept; the third is held.
  - Raising i_ready drains all three in order with no loss or duplication; o_count=3.
- 1000 random bundles with random i_valid/i_ready -> every delivered result equals the golden (a+b+c0) model, in order. o_sum is stable whenever o_valid & ~i_ready.
- Assert i_rst_n low mid-stream while FULL -> o_valid and o_count clear immediately, o_ready=1; the post-reset stream contains no stale entries.
- Preload o_count to 0xFFFF via 65535 transfers, one more transfer -> o_count wraps to 0x0000.
